alarm_ctrl: RTL and testbench
=============================

# alarm_ctrl

Alarm sequencing controller for the BCD watch. Holds a programmable alarm time, compares it against the live hours/minutes from the watch counter, and drives a ring output through an armed/ringing/snoozing state machine timed by the one-second tick from the clock divider. It sits beside the watch in the top level and is the only block that decides when the alarm sounds.

## Interface
- RING_SEC, 60: maximum ring duration in seconds before auto-stop; range 1..255.
- SNOOZE_SEC, 300: snooze interval in seconds; range 1..1023.

- clk  in  1  system clock.
- rstn  in  1  reset, synchronous, active-low.
- sec_tick  in  1  one-cycle pulse per second, synchronous to clk.
- hourdec_now, hourone_now, mindec_now, minone_now  in  4 each  current BCD time.
- alarm_wr  in  1  one-cycle write strobe for the alarm time.
- hourdec_in, hourone_in, mindec_in, minone_in  in  4 each  BCD alarm time, sampled on alarm_wr.
- arm  in  1  level; high enables the alarm.
- stop  in  1  one-cycle pulse; silences the alarm.
- snooze  in  1  one-cycle pulse; requests snooze.
- hourdec_al, hourone_al, mindec_al, minone_al  out  4 each  stored alarm time.
- ring  out  1  alarm sounding.
- state  out  2  IDLE=0, ARMED=1, RINGING=2, SNOOZING=3.
- wr_err  out  1  one-cycle pulse when alarm_wr carries an invalid time.

## Operation
- Reset (rstn low at a clk edge): state IDLE, ring 0, wr_err 0, alarm registers 00:00, second counter 0, match_q 0.
- Alarm write: valid when hourdec≤2, hourone≤9 (≤3 if hourdec=2), mindec≤5, minone≤9. A valid write updates all four digits together. An invalid write leaves them unchanged and pulses wr_err. Writes are accepted in every state and do not change the state.
- match = (current time == stored alarm), combinational. match_q registers match every cycle in every state. trig = match & ~match_q.
- IDLE: leave to ARMED when arm=1.
- ARMED: trig → RINGING; load counter with RING_SEC.
- RINGING: ring=1.
  - stop → ARMED.
  - snooze → SNOOZING; load counter with SNOOZE_SEC.
  - Counter decrements on each sec_tick; reaching 0 → ARMED (auto-stop).
- SNOOZING: ring=0.
  - stop → ARMED.
  - Counter decrements on sec_tick; reaching 0 → RINGING; reload RING_SEC.
- arm=0 forces IDLE from any state; this has priority over all other events.
- Event priority within a cycle: arm=0 > stop > snooze > counter expiry > trig.
- Retrigger: because trig is edge-based, the alarm fires at most once per matching minute. Stopping, or arming mid-minute, does not re-fire until the next time the match occurs.
- A write that makes match rise while in ARMED triggers the alarm.

## Timing
- state and ring are registered. ring rises one cycle after the trig cycle.
- stop and snooze take effect on the next edge: ring is low in the cycle after the pulse.
- Ring duration is RING_SEC sec_tick pulses counted from entry. The first second may be partial.
- wr_err is high in the cycle after alarm_wr. Stored digits update on the same edge.
- sec_tick coinciding with the state entry edge is not counted.

## Configuration
- ALARM_SNOOZE_EN defined: snooze behaves as described above.
- ALARM_SNOOZE_EN undefined:
  - the snooze input is ignored;
  - SNOOZING is unreachable;
  - the counter is sized for RING_SEC only;
  - state encoding is unchanged.

## Structure
- alarm_pkg holds:
  - the state enum (alarm_state_t, 2-bit);
  - the bcd_time_t packed struct of four 4-bit digits;
  - BCD digit limit constants;
  - function bcd_time_valid().
- Sub-module alarm_sec_timer: a loadable down-counter. It decrements on sec_tick and emits a one-cycle expire pulse when it reaches 0. Its width is set by parameter.

## Test plan
- Write 07:30 with the time at 07:29 and arm=1; advance the time to 07:30 → ring=1 one cycle later, state=2.
- Ring with no stop, RING_SEC=3 → ring falls after the 3rd sec_tick, state=1. It does not re-fire while the time is still 07:30.
- While ringing, pulse snooze with SNOOZE_SEC=2 → state=3, ring=0. After 2 sec_ticks, ring=1 again.
- Write 24:00, then 12:60 → wr_err pulses twice and the stored time is unchanged. Then write 23:59 → accepted with no wr_err.
- While ringing, pulse stop and snooze in the same cycle → state=1. While ringing, drop arm → state=0.
- While RINGING, assert rstn low for one edge → ring=0, state=0, alarm 00:00.

Source files
------------

// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types and helpers for the alarm sequencing controller.
// Holds the controller state encoding, the packed BCD time struct, the BCD
// digit limits and the alarm-time validity check used on writes.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RINGING  = 2'd2,
    ST_SNOOZING = 2'd3
  } alarm_state_t;

  typedef struct packed {
    logic [3:0] hourdec;
    logic [3:0] hourone;
    logic [3:0] mindec;
    logic [3:0] minone;
  } bcd_time_t;

  localparam logic [3:0] HOURDEC_MAX    = 4'd2;
  localparam logic [3:0] HOURONE_MAX    = 4'd9;
  localparam logic [3:0] HOURONE_MAX_20 = 4'd3;  // hours 20..23 only
  localparam logic [3:0] MINDEC_MAX     = 4'd5;
  localparam logic [3:0] MINONE_MAX     = 4'd9;

  function automatic logic bcd_time_valid(input bcd_time_t t);
    logic ok;
    ok = (t.hourdec <= HOURDEC_MAX) &&
         (t.hourone <= ((t.hourdec == HOURDEC_MAX) ? HOURONE_MAX_20 : HOURONE_MAX)) &&
         (t.mindec  <= MINDEC_MAX) &&
         (t.minone  <= MINONE_MAX);
    return ok;
  endfunction

endpackage

// File: rtl/alarm_sec_timer.sv
// alarm_sec_timer: loadable down-counter in seconds.
// Ports: clk, rstn (sync active-low), load/load_val (load has priority over
// tick), tick (one-second pulse), expire (combinational, high in the cycle
// whose tick takes the count from 1 to 0).
module alarm_sec_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         expire
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (load) begin
      // a tick on the load edge is deliberately dropped
      cnt_q <= load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = tick && !load && (cnt_q == W'(1));

endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm time register, match/edge detection and the
// idle/armed/ringing/snoozing sequencer for the BCD watch.
// Ports: clk, rstn (sync active-low), sec_tick, *_now (live BCD time),
// alarm_wr + *_in (alarm write), arm (level), stop, snooze (pulses),
// *_al (stored alarm), ring, state, wr_err.
// Build option: ALARM_SNOOZE_EN enables the snooze path; without it the
// snooze input is ignored and the counter only covers RING_SEC.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       sec_tick,
  input  logic [3:0] hourdec_now,
  input  logic [3:0] hourone_now,
  input  logic [3:0] mindec_now,
  input  logic [3:0] minone_now,
  input  logic       alarm_wr,
  input  logic [3:0] hourdec_in,
  input  logic [3:0] hourone_in,
  input  logic [3:0] mindec_in,
  input  logic [3:0] minone_in,
  input  logic       arm,
  input  logic       stop,
  input  logic       snooze,
  output logic [3:0] hourdec_al,
  output logic [3:0] hourone_al,
  output logic [3:0] mindec_al,
  output logic [3:0] minone_al,
  output logic       ring,
  output logic [1:0] state,
  output logic       wr_err
);

`ifdef ALARM_SNOOZE_EN
  localparam int CNT_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  logic snooze_req;
  assign snooze_req = snooze;
`else
  localparam int CNT_MAX = RING_SEC;
  localparam int snooze_sec_unused = SNOOZE_SEC;
  logic snooze_req;
  logic snooze_unused;
  assign snooze_req    = 1'b0;
  assign snooze_unused = snooze;
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  bcd_time_t    now_t, wr_t, al_q;
  alarm_state_t state_q, state_nx;
  logic         match, match_q, trig, wr_ok, wr_err_q;
  logic         tmr_load, tmr_expire;
  logic [CNT_W-1:0] tmr_val;

  assign now_t = {hourdec_now, hourone_now, mindec_now, minone_now};
  assign wr_t  = {hourdec_in, hourone_in, mindec_in, minone_in};
  assign wr_ok = bcd_time_valid(wr_t);
  assign match = (now_t == al_q);
  // rising edge only: one fire per matching minute
  assign trig  = match && !match_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      al_q     <= '0;
      wr_err_q <= 1'b0;
      match_q  <= 1'b0;
      state_q  <= ST_IDLE;
    end else begin
      match_q  <= match;
      wr_err_q <= alarm_wr && !wr_ok;
      if (alarm_wr && wr_ok) al_q <= wr_t;
      state_q  <= state_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    tmr_load = 1'b0;
    tmr_val  = CNT_W'(RING_SEC);
    if (!arm) begin
      state_nx = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_nx = ST_ARMED;
        ST_ARMED: begin
          // stop outranks trig, so a stop pulse masks a coincident fire
          if (!stop && trig) begin
            state_nx = ST_RINGING;
            tmr_load = 1'b1;
          end
        end
        ST_RINGING: begin
          if (stop) begin
            state_nx = ST_ARMED;
          end else if (snooze_req) begin
            state_nx = ST_SNOOZING;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(SNOOZE_SEC);
          end else if (tmr_expire) begin
            state_nx = ST_ARMED;
          end
        end
        ST_SNOOZING: begin
          if (stop) begin
            state_nx = ST_ARMED;
          end else if (tmr_expire) begin
            state_nx = ST_RINGING;
            tmr_load = 1'b1;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  alarm_sec_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (sec_tick),
    .expire   (tmr_expire)
  );

  assign hourdec_al = al_q.hourdec;
  assign hourone_al = al_q.hourone;
  assign mindec_al  = al_q.mindec;
  assign minone_al  = al_q.minone;
  assign state      = state_q;
  assign ring       = (state_q == ST_RINGING);
  assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
module tb_alarm_ctrl;

  localparam int RING  = 3;
  localparam int SNOOZ = 2;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn, sec_tick, alarm_wr, arm, stop, snooze;
  logic [3:0] hd_now, ho_now, md_now, mo_now;
  logic [3:0] hd_in, ho_in, md_in, mo_in;
  logic [3:0] hd_al, ho_al, md_al, mo_al;
  logic ring, wr_err;
  logic [1:0] state;

  always #5 clk = ~clk;

  alarm_ctrl #(.RING_SEC(RING), .SNOOZE_SEC(SNOOZ)) dut (
    .clk(clk), .rstn(rstn), .sec_tick(sec_tick),
    .hourdec_now(hd_now), .hourone_now(ho_now), .mindec_now(md_now), .minone_now(mo_now),
    .alarm_wr(alarm_wr),
    .hourdec_in(hd_in), .hourone_in(ho_in), .mindec_in(md_in), .minone_in(mo_in),
    .arm(arm), .stop(stop), .snooze(snooze),
    .hourdec_al(hd_al), .hourone_al(ho_al), .mindec_al(md_al), .minone_al(mo_al),
    .ring(ring), .state(state), .wr_err(wr_err)
  );

  // ---------------- reference model (minutes-of-day, seconds left) --------
  int         m_mode;   // 0 idle, 1 armed, 2 ringing, 3 snoozing
  int         m_left;   // seconds remaining in ringing/snoozing
  int         m_al_min; // stored alarm as minutes since midnight
  logic [3:0] m_al [4];
  bit         m_err, m_prev;

  logic [19:0] expq [$];
  int checks = 0, passes = 0, cyc = 0;

  function automatic int to_min(input logic [3:0] a, b, c, d);
    return (int'(a) * 10 + int'(b)) * 60 + int'(c) * 10 + int'(d);
  endfunction

  function automatic bit time_ok(input logic [3:0] a, b, c, d);
    return (a <= 4'd2) && (b <= 4'd9) && ((int'(a) * 10 + int'(b)) < 24) &&
           (c <= 4'd5) && (d <= 4'd9);
  endfunction

  task automatic model_step();
    bit hit, fire;
    if (!rstn) begin
      m_mode = 0; m_left = 0; m_err = 0; m_prev = 0; m_al_min = 0;
      for (int i = 0; i < 4; i++) m_al[i] = 4'd0;
      return;
    end
    hit    = (to_min(hd_now, ho_now, md_now, mo_now) == m_al_min);
    fire   = hit && !m_prev;
    m_prev = hit;
    m_err  = alarm_wr && !time_ok(hd_in, ho_in, md_in, mo_in);
    if (alarm_wr && !m_err) begin
      m_al[0] = hd_in; m_al[1] = ho_in; m_al[2] = md_in; m_al[3] = mo_in;
      m_al_min = to_min(hd_in, ho_in, md_in, mo_in);
    end
    if (!arm) m_mode = 0;
    else if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1) begin
      if (!stop && fire) begin m_mode = 2; m_left = RING; end
    end else if (stop) m_mode = 1;
    else if (m_mode == 2 && SNZ_EN && snooze) begin m_mode = 3; m_left = SNOOZ; end
    else if (sec_tick) begin
      m_left--;
      if (m_left == 0) begin
        if (m_mode == 2) m_mode = 1;
        else begin m_mode = 2; m_left = RING; end
      end
    end
  endtask

  // one clock: model predicts the post-edge outputs, pushes them, then clocks
  task automatic cycle();
    model_step();
    expq.push_back({2'(m_mode), m_mode == 2, m_err, m_al[0], m_al[1], m_al[2], m_al[3]});
    @(posedge clk);
    #1;
    cyc++;
    sec_tick = 0; alarm_wr = 0; stop = 0; snooze = 0;
  endtask

  task automatic set_now(input int h, input int m);
    hd_now = 4'(h / 10); ho_now = 4'(h % 10); md_now = 4'(m / 10); mo_now = 4'(m % 10);
  endtask

  task automatic write_al(input logic [3:0] a, b, c, d);
    alarm_wr = 1; hd_in = a; ho_in = b; md_in = c; mo_in = d;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(); cycle();
      sec_tick = 1; cycle();
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    logic [19:0] e, got;
    #3;
    if (expq.size() > 0) begin
      e   = expq.pop_front();
      got = {state, ring, wr_err, hd_al, ho_al, md_al, mo_al};
      checks++;
      if (got === e) passes++;
      else $display("FAIL cyc%0d outputs got st=%0d ring=%b err=%b al=%h required st=%0d ring=%b err=%b al=%h",
                    cyc, got[19:18], got[17], got[16], got[15:0], e[19:18], e[17], e[16], e[15:0]);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rstn = 0; sec_tick = 0; alarm_wr = 0; arm = 0; stop = 0; snooze = 0;
    hd_in = 0; ho_in = 0; md_in = 0; mo_in = 0;
    set_now(7, 29);
    cycle(); cycle();
    rstn = 1;
    // program 07:30 and arm
    arm = 1; write_al(4'd0, 4'd7, 4'd3, 4'd0); cycle();
    cycle(); cycle();
    set_now(7, 30); cycle(); cycle();
    // auto-stop after RING ticks; no re-fire while still 07:30
    tick_n(RING); tick_n(2);
    set_now(7, 31); cycle();
    set_now(7, 30); cycle(); cycle();
    // snooze then ring again after SNOOZ ticks
    snooze = 1; cycle();
    tick_n(SNOOZ); cycle();
    // stop and snooze together
    stop = 1; snooze = 1; cycle(); cycle();
    set_now(7, 31); cycle(); set_now(7, 30); cycle(); cycle();
    arm = 0; cycle(); arm = 1; cycle();
    // invalid writes then a valid 23:59
    write_al(4'd2, 4'd4, 4'd0, 4'd0); cycle();
    write_al(4'd1, 4'd2, 4'd6, 4'd0); cycle();
    write_al(4'd2, 4'd3, 4'd5, 4'd9); cycle();
    set_now(23, 59); cycle(); cycle();
    rstn = 0; cycle(); rstn = 1; cycle(); cycle();

    // randomized phase
    for (int i = 0; i < 4000; i++) begin
      rstn     = ($urandom_range(0, 999) != 0);
      if ($urandom_range(0, 199) == 0) arm = ~arm;
      sec_tick = ($urandom_range(0, 2) == 0);
      stop     = ($urandom_range(0, 39) == 0);
      snooze   = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          hd_now = m_al[0]; ho_now = m_al[1]; md_now = m_al[2]; mo_now = m_al[3];
        end else set_now($urandom_range(0, 23), $urandom_range(0, 59));
      end
      if ($urandom_range(0, 59) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          hd_in = 4'($urandom_range(0, 2));
          ho_in = 4'((hd_in == 4'd2) ? $urandom_range(0, 3) : $urandom_range(0, 9));
          md_in = 4'($urandom_range(0, 5));
          mo_in = 4'($urandom_range(0, 9));
        end else begin
          hd_in = 4'($urandom_range(0, 15)); ho_in = 4'($urandom_range(0, 15));
          md_in = 4'($urandom_range(0, 15)); mo_in = 4'($urandom_range(0, 15));
        end
        alarm_wr = 1;
      end
      cycle();
    end

    repeat (2) @(posedge clk);
    #5;
    checks++;
    if (expq.size() == 0) passes++;
    else $display("FAIL drain queue left=%0d required=0", expq.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
